// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with valid/ready handshakes and div-zero/overflow flags.
// Signed operation is compiled in only when SEQ_DIVIDER_SIGNED_EN is defined; otherwise all ops are unsigned.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] reminder,
    output logic             div_zero,
    output logic             overflow
);
    // state | meaning
    // IDLE  | ready; operands captured on in_valid
    // BUSY  | one restoring step per cycle, WIDTH steps
    // FIX   | sign correction, outputs latched
    // DONE  | result held until out_ready
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dz_out_q, dz_out_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
    logic [WIDTH:0]   rem_sh;
    logic             take;
    logic             unused_bits;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic a_neg, b_neg, ovf_in;
    logic nega_q, nega_d, negq_q, negq_d, ovf_q, ovf_d, ovf_out_q, ovf_out_d;

    assign a_neg  = sign && a[WIDTH-1];
    assign b_neg  = sign && b[WIDTH-1];
    // -MIN_VAL wraps to itself, which is exactly its unsigned magnitude
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    assign ovf_in = sign && (a == MIN_VAL) && (b == '1);

    assign nega_d    = (state_q == S_IDLE && in_valid) ? a_neg : nega_q;
    assign negq_d    = (state_q == S_IDLE && in_valid) ? (a_neg ^ b_neg) : negq_q;
    assign ovf_d     = (state_q == S_IDLE && in_valid) ? ovf_in : ovf_q;
    assign ovf_out_d = (state_q == S_FIX) ? ovf_q : ovf_out_q;

    assign q_fix    = negq_q ? -dvd_q : dvd_q;
    assign r_fix    = nega_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    assign overflow = ovf_out_q;
    assign unused_bits = rem_q[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            nega_q    <= 1'b0;
            negq_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            nega_q    <= nega_d;
            negq_q    <= negq_d;
            ovf_q     <= ovf_d;
            ovf_out_q <= ovf_out_d;
        end
    end
`else
    assign a_mag    = a;
    assign b_mag    = b;
    assign q_fix    = dvd_q;
    assign r_fix    = rem_q[WIDTH-1:0];
    assign overflow = 1'b0;
    assign unused_bits = ^{sign, rem_q[WIDTH]};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        dz_d        = dz_q;
        quo_d       = quo_q;
        rmd_d       = rmd_q;
        dz_out_d    = dz_out_q;
        out_valid_d = out_valid_q;
        // dvd_q shifts the dividend out at the top and the quotient in at the bottom
        rem_sh      = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        take        = (rem_sh >= {1'b0, dvs_q});
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dz_d    = (b == '0);
                    dvd_d   = a_mag;
                    dvs_d   = b_mag;
                    cnt_d   = CNT_LAST;
                    // on divide-by-zero the raw dividend rides in rem_q straight to FIX
                    rem_d   = (b == '0) ? {1'b0, a} : '0;
                    state_d = (b == '0) ? S_FIX : S_BUSY;
                end
            end
            S_BUSY: begin
                rem_d = take ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
                dvd_d = {dvd_q[WIDTH-2:0], take};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quo_d       = dz_q ? '1 : q_fix;
                rmd_d       = dz_q ? rem_q[WIDTH-1:0] : r_fix;
                dz_out_d    = dz_q;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            dz_q        <= 1'b0;
            quo_q       <= '0;
            rmd_q       <= '0;
            dz_out_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            dz_q        <= dz_d;
            quo_q       <= quo_d;
            rmd_q       <= rmd_d;
            dz_out_q    <= dz_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quo_q;
    assign reminder  = rmd_q;
    assign div_zero  = dz_out_q;
endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle radix-2 restoring integer divider, parametrised in width, with signed/unsigned mode selected per operation. It is the sequential successor to the combinational `divider`: it keeps the same operand, quotient, remainder and sign semantics, and adds valid/ready handshakes, divide-by-zero and overflow flags, and a fixed iterative latency. It sits behind the ALU issue stage, where a full-width combinational divider would not meet timing.

## Interface
- `WIDTH`, 8: operand, quotient and remainder width in bits; must be ≥ 2.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: an operand pair is presented.
- `in_ready`  out  1: the divider can accept an operand pair.
- `a`  in  WIDTH: dividend.
- `b`  in  WIDTH: divisor.
- `sign`  in  1: 1 means operands and results are two's-complement; 0 means unsigned.
- `out_valid`  out  1: a result is presented.
- `out_ready`  in  1: the consumer accepts the result.
- `quotient`  out  WIDTH: quotient.
- `reminder`  out  WIDTH: remainder. The spelling matches `divider`.
- `div_zero`  out  1: the divisor was 0.
- `overflow`  out  1: signed minimum divided by -1.

## Operation
- FSM states: IDLE, BUSY, FIX, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid` the FSM captures `a`, `b` and `sign`.
  - It then captures |a| and |b| when `sign`=1 and the operand is negative; otherwise it captures the raw values.
  - Next state is BUSY, or FIX if b==0.
- BUSY:
  - One restoring step per cycle, for WIDTH cycles, MSB first.
  - Each step: shift the partial remainder left, bringing in the next dividend bit; trial-subtract the divisor; keep the difference if it is non-negative and shift 1 into the quotient, otherwise shift 0.
  - The iteration counter runs WIDTH-1 down to 0. At 0 the next state is FIX.
- FIX (one cycle): apply signs and latch the outputs.
  - The quotient is negated if `sign` is set and the operand signs differ. Division truncates toward zero.
  - The remainder is negated if `sign` is set and the dividend was negative, so the remainder sign follows the dividend.
  - Next state is DONE.
- DONE:
  - `out_valid`=1 and the outputs are held stable.
  - On `out_ready` the next state is IDLE.
  - `in_ready` stays 0 during DONE: there is no overlap of operations.
- Divide by zero: `quotient` = all ones, `reminder` = `a` (raw), `div_zero`=1. The BUSY phase is skipped.
- Overflow: signed `a` = -2^(WIDTH-1) with `b` = -1 gives `quotient` = -2^(WIDTH-1), `reminder` = 0, `overflow`=1.
  - This is the natural result of the magnitude arithmetic truncated to WIDTH bits; it needs no special datapath, only the flag.
- Internal arithmetic: the partial remainder is WIDTH+1 bits. The magnitude of the signed minimum is held unsigned in WIDTH bits.

## Timing
- Reset values:
  - state = IDLE
  - `in_ready`=1 (combinational from state, so 1 in the cycle after `rst` deasserts)
  - `out_valid`=0
  - `quotient`=0, `reminder`=0
  - `div_zero`=0, `overflow`=0
- Latency:
  - Operands are accepted on edge T.
  - `out_valid` rises after edge T+WIDTH+1, i.e. WIDTH+2 cycles for normal operations.
  - For divide by zero it rises after edge T+1.
- Throughput: one operation per WIDTH+3 cycles when `out_ready` is held at 1.
- Handshake:
  - A transfer occurs when valid and ready are both 1 on the same edge.
  - `in_ready` is purely a function of state; `out_valid` is registered.
- Backpressure: with `out_ready`=0 the divider holds DONE and all outputs indefinitely.
- `rst` at any state returns to IDLE on the next edge and discards the in-flight operation. `out_valid` is 0 in the following cycle.
- The `in_valid` value in a cycle where `rst`=1 is ignored.

## Configuration
- `SEQ_DIVIDER_SIGNED_EN`
  - Defined: the `sign` port is honoured, including the sign-fix logic and the `overflow` flag.
  - Undefined: `sign` is ignored and every operation is unsigned. FIX does a plain copy with no negation, `overflow` is tied to 0, and the sign and negation logic is removed.

## Test plan
- WIDTH=8, `sign`=1:
  - 42/7 → q=6, r=0, `out_valid` high exactly 10 cycles after the accept edge.
  - -42/7 → q=-6, r=0.
  - 7/-42 → q=0, r=7.
  - 127/37 → q=3, r=16.
- WIDTH=8, `sign`=1, -128/-1 → q=-128, r=0, `overflow`=1, `div_zero`=0. With the macro undefined the same bits give 128/255 → q=0, r=128, `overflow`=0.
- `sign`=0, 200/0 → q=255, r=200, `div_zero`=1, `out_valid` after 2 edges.
- Backpressure: 10/12 with `out_ready`=0 for 5 cycles → q=0, r=10 held stable, `in_ready`=0 throughout; the result is consumed when `out_ready`=1 and `in_ready` returns the next cycle.
- Reset mid-BUSY: `rst` on the 4th iteration → IDLE next cycle, `out_valid`=0. A following 42/42 → q=1, r=0 with normal latency.
- Randomised sweep, WIDTH=16 and WIDTH=5, both modes: the bench checks that quotient×b + reminder == a, and that |reminder| < |b| for every b≠0.
